board_pixel_streamer: RTL and testbench

- Sequences the piece-code-to-colour datapath for display output; one board cell per handshake.
- On `frame_start`, snapshots the full 12x10 board of 4-bit piece codes, so game-logic updates mid-frame cannot tear the image.
- Then streams cells in raster order (row 0 col 0 first, columns fastest), each converted to an 8-bit colour.
- Sits between the game-state logic and the display/LED-matrix driver, which pulls pixels through a valid/ready interface.

---
 rtl/tetris_pkg.sv | 35 +++
 rtl/piece_color_lut.sv | 27 ++
 rtl/board_pixel_streamer.sv | 117 +++++++++++
 tb/tb_board_pixel_streamer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared piece codes, colours, board defaults and the streamer state type,
// reused by game logic and the renderer.
package tetris_pkg;

    localparam int ROWS_DEF = 12;
    localparam int COLS_DEF = 10;

    localparam logic [3:0] PC_EMPTY  = 4'd0;
    localparam logic [3:0] PC_T      = 4'd1;
    localparam logic [3:0] PC_SQUARE = 4'd2;
    localparam logic [3:0] PC_J      = 4'd3;
    localparam logic [3:0] PC_L      = 4'd4;
    localparam logic [3:0] PC_Z      = 4'd5;
    localparam logic [3:0] PC_S      = 4'd6;
    localparam logic [3:0] PC_LINE   = 4'd7;
    localparam logic [3:0] PC_CURSED = 4'd8;

    localparam logic [7:0] COL_EMPTY  = 8'h00;
    localparam logic [7:0] COL_T      = 8'hF0;
    localparam logic [7:0] COL_SQUARE = 8'hF9;
    localparam logic [7:0] COL_J      = 8'h14;
    localparam logic [7:0] COL_L      = 8'h7F;
    localparam logic [7:0] COL_Z      = 8'h4F;
    localparam logic [7:0] COL_S      = 8'h8F;
    localparam logic [7:0] COL_LINE   = 8'hF3;
    localparam logic [7:0] COL_CURSED = 8'hC0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_e;

endpackage

// File: rtl/piece_color_lut.sv
// Single-cell piece-code to display-colour map; the only place the colour
// table lives, shared by every board-to-colour converter.
module piece_color_lut #(
    parameter int CODE_W  = 4,
    parameter int COLOR_W = 8
) (
    input  logic [CODE_W-1:0]  code_i,
    output logic [COLOR_W-1:0] color_o
);
    import tetris_pkg::*;

    always_comb begin
        color_o = COLOR_W'(COL_EMPTY);
        case (code_i)
            CODE_W'(PC_T):      color_o = COLOR_W'(COL_T);
            CODE_W'(PC_SQUARE): color_o = COLOR_W'(COL_SQUARE);
            CODE_W'(PC_J):      color_o = COLOR_W'(COL_J);
            CODE_W'(PC_L):      color_o = COLOR_W'(COL_L);
            CODE_W'(PC_Z):      color_o = COLOR_W'(COL_Z);
            CODE_W'(PC_S):      color_o = COLOR_W'(COL_S);
            CODE_W'(PC_LINE):   color_o = COLOR_W'(COL_LINE);
            CODE_W'(PC_CURSED): color_o = COLOR_W'(COL_CURSED);
            default:            ;
        endcase
    end

endmodule

// File: rtl/board_pixel_streamer.sv
// Snapshots the board on frame_start, then streams one colour pixel per
// valid/ready handshake in raster order (columns fastest).
module board_pixel_streamer
    import tetris_pkg::*;
#(
    parameter int ROWS    = ROWS_DEF,
    parameter int COLS    = COLS_DEF,
    parameter int CODE_W  = 4,
    parameter int COLOR_W = 8,
    parameter int IDX_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_start,
    input  logic [ROWS*COLS*CODE_W-1:0] board,
    output logic                        busy,
    output logic                        px_valid,
    input  logic                        px_ready,
    output logic [IDX_W-1:0]            px_row,
    output logic [IDX_W-1:0]            px_col,
    output logic [COLOR_W-1:0]          px_color,
    output logic                        px_last,
    output logic                        frame_done
);

    stream_state_e     state_q, state_d;
    logic [IDX_W-1:0]  row_q, row_d;
    logic [IDX_W-1:0]  col_q, col_d;
    logic [CODE_W-1:0] snap_q [ROWS][COLS];
    logic              capture;
    logic              at_last_col;
    logic              at_last_row;
    logic [CODE_W-1:0] cur_code;

    assign at_last_col = (col_q == IDX_W'(COLS - 1));
    assign at_last_row = (row_q == IDX_W'(ROWS - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    capture = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_STREAM;
            ST_STREAM: begin
                // px_valid is implied in this state, so ready alone completes a handshake
                if (px_ready) begin
                    if (!at_last_col) begin
                        col_d = col_q + IDX_W'(1);
                    end else if (!at_last_row) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    snap_q[r][c] <= '0;
                end
            end
        end else if (capture) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    snap_q[r][c] <= board[(r*COLS + c)*CODE_W +: CODE_W];
                end
            end
        end
    end

    assign cur_code = snap_q[row_q][col_q];

    piece_color_lut #(
        .CODE_W (CODE_W),
        .COLOR_W(COLOR_W)
    ) u_lut (
        .code_i (cur_code),
        .color_o(px_color)
    );

    // Every status output decodes straight from the state so an async reset clears them at once
    assign px_valid   = (state_q == ST_STREAM);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign px_last    = px_valid & at_last_row & at_last_col;
    assign px_row     = row_q;
    assign px_col     = col_q;

endmodule

// File: tb/tb_board_pixel_streamer.sv
// Scoreboard bench for board_pixel_streamer: frames are predicted from a
// board array and the colour table, a monitor pops and compares each handshake.
module tb_board_pixel_streamer;

    localparam int ROWS    = 12;
    localparam int COLS    = 10;
    localparam int CODE_W  = 4;
    localparam int COLOR_W = 8;
    localparam int IDX_W   = 4;
    localparam int NCELL   = ROWS * COLS;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        frame_start;
    logic [ROWS*COLS*CODE_W-1:0] board;
    logic                        busy;
    logic                        px_valid;
    logic                        px_ready;
    logic [IDX_W-1:0]            px_row;
    logic [IDX_W-1:0]            px_col;
    logic [COLOR_W-1:0]          px_color;
    logic                        px_last;
    logic                        frame_done;

    logic [3:0] bm [ROWS][COLS];

    typedef struct {
        int         row;
        int         col;
        logic [7:0] color;
        logic       last;
    } pix_t;

    pix_t exp_q[$];

    int total    = 0;
    int bad      = 0;
    int hs_frame = 0;
    int done_cnt = 0;
    int stop_at  = 1000000;
    bit rnd_ready = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        board = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                board[(r*COLS + c)*CODE_W +: CODE_W] = bm[r][c];
            end
        end
    end

    board_pixel_streamer #(
        .ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W), .COLOR_W(COLOR_W), .IDX_W(IDX_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .board      (board),
        .busy       (busy),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_row     (px_row),
        .px_col     (px_col),
        .px_color   (px_color),
        .px_last    (px_last),
        .frame_done (frame_done)
    );

    function automatic logic [7:0] ref_color(input logic [3:0] code);
        case (code)
            4'd1:    return 8'hF0;
            4'd2:    return 8'hF9;
            4'd3:    return 8'h14;
            4'd4:    return 8'h7F;
            4'd5:    return 8'h4F;
            4'd6:    return 8'h8F;
            4'd7:    return 8'hF3;
            4'd8:    return 8'hC0;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor();
        logic       stall = 1'b0;
        logic [3:0] sr = '0;
        logic [3:0] sc = '0;
        logic [7:0] scol = '0;
        pix_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall && px_valid) begin
                check("hold_row", 32'(px_row), 32'(sr));
                check("hold_col", 32'(px_col), 32'(sc));
                check("hold_color", 32'(px_color), 32'(scol));
            end
            if (px_valid && px_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'(hs_frame), 32'(NCELL));
                end else begin
                    e = exp_q.pop_front();
                    check("px_row", 32'(px_row), 32'(e.row));
                    check("px_col", 32'(px_col), 32'(e.col));
                    check("px_color", 32'(px_color), 32'(e.color));
                    check("px_last", 32'(px_last), 32'(e.last));
                end
                hs_frame++;
            end
            if (frame_done) begin
                done_cnt++;
                check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
            end
            stall = px_valid && !px_ready;
            sr    = px_row;
            sc    = px_col;
            scol  = px_color;
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            px_ready = (hs_frame < stop_at) && (rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                exp_q.push_back('{r, c, ref_color(bm[r][c]), (r == ROWS-1 && c == COLS-1)});
            end
        end
        hs_frame = 0;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start = done_cnt;
        bit seen  = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != start) seen = 1'b1;
        end
        check({name, "_done_count"}, 32'(done_cnt), 32'(start + 1));
        check({name, "_handshakes"}, 32'(hs_frame), 32'(NCELL));
        #1;
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_done_one_cycle"}, 32'(frame_done), 32'd0);
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                bm[r][c] = 4'($urandom_range(0, 15));
    endtask

    task automatic fill_const(input logic [3:0] v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                bm[r][c] = v;
    endtask

    initial begin
        int dstart;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        px_ready    = 1'b0;
        fill_const(4'd0);
        fork
            monitor();
            ready_drv();
        join_none

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_px_valid", 32'(px_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_px_last", 32'(px_last), 32'd0);
        check("rst_px_row", 32'(px_row), 32'd0);
        check("rst_px_col", 32'(px_col), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // directed frame, ready held high, latency checks
        bm[0][0]  = 4'd1;
        bm[0][9]  = 4'd7;
        bm[11][9] = 4'd8;
        rnd_ready = 1'b0;
        start_frame();
        @(negedge clk);
        check("lat_load_valid", 32'(px_valid), 32'd0);
        check("lat_load_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_stream_valid", 32'(px_valid), 32'd1);
        check("lat_first_row", 32'(px_row), 32'd0);
        check("lat_first_col", 32'(px_col), 32'd0);
        wait_done("directed");

        // random backpressure
        rnd_ready = 1'b1;
        fill_random();
        start_frame();
        wait_done("backpressure");

        // snapshot isolation, then a frame of the overwritten board
        fill_random();
        start_frame();
        fill_const(4'd2);
        wait_done("snapshot");
        start_frame();
        wait_done("all_square");

        // ignored frame_start in STREAM at (5,3) and in DONE
        rnd_ready = 1'b0;
        fill_random();
        dstart = done_cnt;
        start_frame();
        for (int i = 0; i < 1000 && hs_frame != 53; i++) begin
            @(posedge clk);
            #1;
        end
        check("reach_cell_5_3", 32'(hs_frame), 32'd53);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        check("ignored_reached_done", 32'(frame_done), 32'd1);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ignored_idle_busy", 32'(busy), 32'd0);
        end
        check("ignored_done_count", 32'(done_cnt), 32'(dstart + 1));
        check("ignored_handshakes", 32'(hs_frame), 32'(NCELL));
        check("ignored_queue_empty", 32'(exp_q.size()), 32'd0);

        // illegal and empty codes
        rnd_ready = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                bm[r][c] = 4'((r*COLS + c) % 16);
        start_frame();
        wait_done("code_sweep");

        // async reset while stalled at (6,4)
        rnd_ready = 1'b0;
        stop_at   = 64;
        fill_random();
        start_frame();
        for (int i = 0; i < 1000 && hs_frame != 64; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("stall_valid", 32'(px_valid), 32'd1);
        check("stall_row", 32'(px_row), 32'd6);
        check("stall_col", 32'(px_col), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_px_valid", 32'(px_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_px_last", 32'(px_last), 32'd0);
        dstart = done_cnt;
        exp_q.delete();
        repeat (3) @(posedge clk);
        check("async_no_done", 32'(done_cnt), 32'(dstart));
        check("async_frame_done_low", 32'(frame_done), 32'd0);
        stop_at = 1000000;
        #1;
        rst_n = 1'b1;
        rnd_ready = 1'b1;
        fill_random();
        start_frame();
        wait_done("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
